// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage of a 5-stage MIPS pipeline. Owns the program
//   counter, drives the instruction-memory address and latches the IF/ID
//   pipeline register. Applies the hazard-unit stall and the decode-stage
//   redirect/flush, and keeps saturating stall/flush event counters.
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rst_i        synchronous active-high reset
//   start_i      run enable (0 = front end idle, IF/ID fed bubbles)
//   stall_i      load-use stall: hold PC and IF/ID
//   branch_i     taken branch/jump resolved in ID: redirect and flush
//   target_i     redirect address (low two bits ignored)
//   instr_i      instruction-memory read data for address pc_o
//   pc_o         current PC / instruction-memory address
//   if_pc4_o     IF/ID latched PC+4
//   if_instr_o   IF/ID latched instruction
//   if_valid_o   IF/ID holds a real instruction (0 = bubble)
//   stall_cnt_o  accepted stall cycles, saturating
//   flush_cnt_o  accepted flush cycles, saturating
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic [31:0]      target_i,
  input  logic [31:0]      instr_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      if_pc4_o,
  output logic [31:0]      if_instr_o,
  output logic             if_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pc4_q, pc4_d;
  logic [31:0]      instr_q, instr_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [31:0]      pc_plus4;

  // Modulo-2^32 increment: 0xFFFF_FFFC wraps to 0 with no flag.
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d        = pc_q;
    pc4_d       = pc4_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (!start_i) begin
      // Idle: PC frozen, decode sees nops.
      pc4_d   = '0;
      instr_d = '0;
      valid_d = 1'b0;
    end else if (stall_i) begin
      // Stall outranks branch: the branch operand is still pending, so the
      // redirect is re-presented on a later cycle.
      if (stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end else if (branch_i) begin
      // Force word alignment so a misaligned target never reaches pc_o.
      pc_d    = {target_i[31:2], 2'b00};
      pc4_d   = '0;
      instr_d = '0;
      valid_d = 1'b0;
      if (flush_cnt_q != {CNT_W{1'b1}}) begin
        flush_cnt_d = flush_cnt_q + 1'b1;
      end
    end else begin
      pc_d    = pc_plus4;
      pc4_d   = pc_plus4;
      instr_d = instr_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q        <= RESET_PC;
      pc4_q       <= '0;
      instr_q     <= '0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      pc4_q       <= pc4_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pc_o        = pc_q;
  assign if_pc4_o    = pc4_q;
  assign if_instr_o  = instr_q;
  assign if_valid_o  = valid_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage. Counters are built 4 bits wide so
// saturation is reachable in a few cycles.
module tb_fetch_stage;

  localparam int CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i, start_i, stall_i, branch_i;
  logic [31:0]      target_i, instr_i;
  logic [31:0]      pc_o, if_pc4_o, if_instr_o;
  logic             if_valid_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  logic [31:0] imem [0:255];

  int n_checks = 0;
  int n_pass   = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .stall_i     (stall_i),
    .branch_i    (branch_i),
    .target_i    (target_i),
    .instr_i     (instr_i),
    .pc_o        (pc_o),
    .if_pc4_o    (if_pc4_o),
    .if_instr_o  (if_instr_o),
    .if_valid_o  (if_valid_o),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Combinational instruction memory, word-indexed by pc[9:2].
  always_comb instr_i = imem[pc_o[9:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  // Check the full output set in one call.
  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] pc4,
                         input logic [31:0] ins, input logic vld,
                         input logic [31:0] sc, input logic [31:0] fc);
    chk({tag, ".pc"},    pc_o, pc);
    chk({tag, ".pc4"},   if_pc4_o, pc4);
    chk({tag, ".instr"}, if_instr_o, ins);
    chk({tag, ".valid"}, {31'd0, if_valid_o}, {31'd0, vld});
    chk({tag, ".scnt"},  {28'd0, stall_cnt_o}, sc);
    chk({tag, ".fcnt"},  {28'd0, flush_cnt_o}, fc);
    $display("%s pc=%h pc4=%h instr=%h valid=%0b stall=%0d flush=%0d",
             tag, pc_o, if_pc4_o, if_instr_o, if_valid_o, stall_cnt_o, flush_cnt_o);
  endtask

  localparam logic [31:0] A = 32'h2001_0001;
  localparam logic [31:0] B = 32'h2002_0002;
  localparam logic [31:0] C = 32'h2003_0003;
  localparam logic [31:0] D = 32'h2004_0004;  // imem[0x40]
  localparam logic [31:0] E = 32'h2005_0005;  // imem[0x44]
  localparam logic [31:0] F = 32'h2006_0006;  // imem[0xFFFFFFFC] aliases index 255

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'hDEAD_0000 | i;
    imem[0] = A; imem[1] = B; imem[2] = C; imem[3] = 32'h1000_00FF;
    imem[16] = D; imem[17] = E; imem[255] = F;

    rst_i = 1; start_i = 0; stall_i = 0; branch_i = 0; target_i = 0;
    step;
    chk_all("reset", 0, 0, 0, 0, 0, 0);

    rst_i = 0; start_i = 1;
    step; chk_all("fetchA", 32'h4, 32'h4, A, 1, 0, 0);
    step; chk_all("fetchB", 32'h8, 32'h8, B, 1, 0, 0);

    stall_i = 1;
    step; chk_all("stall1", 32'h8, 32'h8, B, 1, 1, 0);
    step; chk_all("stall2", 32'h8, 32'h8, B, 1, 2, 0);
    stall_i = 0;
    step; chk_all("fetchC", 32'hC, 32'hC, C, 1, 2, 0);

    branch_i = 1; target_i = 32'h0000_0043;
    step; chk_all("branch", 32'h40, 0, 0, 0, 2, 1);
    branch_i = 0;
    step; chk_all("tgtD", 32'h44, 32'h44, D, 1, 2, 1);

    // Stall and branch together: stall wins, branch not counted.
    stall_i = 1; branch_i = 1; target_i = 32'h0000_0080;
    step; chk_all("stl+br", 32'h44, 32'h44, D, 1, 3, 1);
    stall_i = 0;
    step; chk_all("br_after", 32'h80, 0, 0, 0, 3, 2);

    // Reach the top of the address space, then wrap.
    target_i = 32'hFFFF_FFFF;
    step; chk_all("br_top", 32'hFFFF_FFFC, 0, 0, 0, 3, 3);
    branch_i = 0;
    step; chk_all("wrap", 0, 0, F, 1, 3, 3);

    // Idle: PC held, bubbles, counters frozen (stall ignored while idle).
    start_i = 0;
    step; chk_all("idle1", 0, 0, 0, 0, 3, 3);
    stall_i = 1;
    step; chk_all("idle2", 0, 0, 0, 0, 3, 3);

    // Saturate stall counter: 3 + 12 = 15, then one more stays 15.
    start_i = 1;
    for (int i = 0; i < 12; i++) step;
    chk_all("sat15", 0, 0, 0, 0, 15, 3);
    step; chk_all("sat_hold", 0, 0, 0, 0, 15, 3);

    // Reset mid-stall with a pending redirect.
    rst_i = 1; branch_i = 1; target_i = 32'h0000_0100;
    step; chk_all("rst_mid", 0, 0, 0, 0, 0, 0);

    rst_i = 0; stall_i = 0; branch_i = 0;
    step; chk_all("restart", 32'h4, 32'h4, A, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the program counter, drives the instruction-memory address, and latches the IF/ID pipeline register consumed by decode, hazard detection and branch resolution. It applies the hazard unit's stall and the decode stage's taken-branch/jump redirect and flush. It also keeps saturating stall and flush event counters for the testbench's per-cycle performance report.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_W, 32, width of stall/flush counters
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  run enable; 0 = pipeline front end idle
- stall_i  in  1  hazard-unit stall (load-use); hold PC and IF/ID
- branch_i  in  1  taken branch/jump resolved in ID; redirect and flush
- target_i  in  32  redirect address, valid when branch_i=1
- instr_i  in  32  instruction-memory read data for address pc_o (combinational)
- pc_o  out  32  current PC, instruction-memory address
- if_pc4_o  out  32  IF/ID latched PC+4
- if_instr_o  out  32  IF/ID latched instruction
- if_valid_o  out  1  IF/ID holds a real instruction (0 = bubble)
- stall_cnt_o  out  CNT_W  accepted stall cycles
- flush_cnt_o  out  CNT_W  accepted flush cycles

## Operation
- Per-edge action, strict priority:
  - rst_i=1: pc_o<=RESET_PC; if_pc4_o<=0; if_instr_o<=0; if_valid_o<=0; both counters<=0.
  - start_i=0: PC holds; IF/ID loads bubble (pc4=0, instr=0, valid=0); counters hold.
  - stall_i=1: PC holds; IF/ID holds all fields; stall_cnt_o+1. branch_i ignored this cycle (operand still pending); flush_cnt_o not incremented.
  - branch_i=1: pc_o<={target_i[31:2],2'b00}; IF/ID loads bubble; flush_cnt_o+1.
  - otherwise: pc_o<=pc_o+4; if_pc4_o<=pc_o+4; if_instr_o<=instr_i; if_valid_o<=1.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC+4 = 0; no error flag.
- Target low two bits forced to 00; misalignment never reaches pc_o.
- Counters saturate at all-ones; never wrap.
- Bubble is all-zero instr (sll $0,$0,0 = nop), so decode needs no valid qualification for correctness.

## Timing
- All outputs registered; no combinational path from any input to any output.
- Fetch latency: instruction at pc_o appears on if_instr_o one edge later.
- Redirect: branch_i high at edge N -> pc_o=target at N; if_valid_o=0 for cycle after N; target's instruction in IF/ID after edge N+1. One-cycle flush penalty.
- Stall of k consecutive cycles holds pc_o and IF/ID exactly k cycles; stall_cnt_o rises by k.
- Reset mid-operation (during stall or redirect) takes effect at that edge; pending redirect discarded.
- After reset release with start_i=1, first instruction (RESET_PC) in IF/ID after first edge.

## Test plan
- Reset: rst_i=1 one edge, then start_i=1, imem[0..2]=A,B,C -> pc_o 0,4,8,12 on successive edges; if_instr_o A,B,C; if_pc4_o 4,8,12; counters 0.
- Stall: at pc_o=8, stall_i=1 for 2 cycles -> pc_o stays 8, if_instr_o stays B for 2 cycles, stall_cnt_o=2, then resumes C.
- Branch: at pc_o=12, branch_i=1, target_i=32'h0000_0043 -> pc_o=0x40 next, if_valid_o=0 and if_instr_o=0 one cycle, flush_cnt_o=1, then imem[0x40] latched.
- Simultaneous: stall_i=1 and branch_i=1 same edge -> PC/IF/ID hold, stall_cnt_o+1, flush_cnt_o unchanged; branch_i alone next edge redirects normally.
- Wrap/idle: force pc_o=32'hFFFF_FFFC, step -> pc_o=0; start_i=0 two edges -> pc_o held, if_valid_o=0, counters unchanged.
- Saturation: preload stall_cnt_o=all-ones, stall one cycle -> stays all-ones; rst_i mid-stall -> all outputs to reset values next edge.
